// File: rtl/npu_result_reader.sv
// npu_result_reader: streams layer results from memory port B to the SPI TX shifter.
// One word per handshake: read, capture, wait for tx_ready, load.
//
// Ports:
//   clk            system clock, rising edge
//   reset_b        asynchronous reset, active high
//   start_readback request to start streaming (sampled in IDLE only)
//   abort          synchronous cancel, highest priority
//   layer_postion  selects result base address (latched at start)
//   neuron_count   number of words to stream (latched at start)
//   mem_rd_en      port B read strobe
//   mem_addr       port B address (0 when mem_rd_en is low)
//   mem_rd_data    port B read data, valid one cycle after mem_rd_en
//   tx_ready       SPI shifter can accept a word
//   tx_load        single-cycle load strobe for the SPI shifter
//   tx_data        word to transmit (0 when tx_load is low)
//   busy           high in every state except IDLE
//   done           one-cycle pulse after the last word is loaded
//   words_sent     tx_load strobes in the current/last transfer
module npu_result_reader #(
    parameter int NPU_DATA_WIDTH = 16,
    parameter int BASE_ADDR_EVEN = 20400,
    parameter int BASE_ADDR_ODD  = 20440
) (
    input  logic                      clk,
    input  logic                      reset_b,
    input  logic                      start_readback,
    input  logic                      abort,
    input  logic                      layer_postion,
    input  logic [NPU_DATA_WIDTH-1:0] neuron_count,
    output logic                      mem_rd_en,
    output logic [NPU_DATA_WIDTH-1:0] mem_addr,
    input  logic [NPU_DATA_WIDTH-1:0] mem_rd_data,
    input  logic                      tx_ready,
    output logic                      tx_load,
    output logic [NPU_DATA_WIDTH-1:0] tx_data,
    output logic                      busy,
    output logic                      done,
    output logic [NPU_DATA_WIDTH-1:0] words_sent
);

    localparam int W = NPU_DATA_WIDTH;

    localparam logic [W-1:0] BASE_EVEN = W'(BASE_ADDR_EVEN);
    localparam logic [W-1:0] BASE_ODD  = W'(BASE_ADDR_ODD);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_TX_WAIT  = 3'd3,
        S_TX_LOAD  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t         state;
    state_t         state_dec;
    state_t         state_nxt;

    logic [W-1:0]   base_q;
    logic [W-1:0]   total_q;
    logic [W-1:0]   index_q;
    logic [W-1:0]   hold_q;
    logic [W-1:0]   sent_q;

    logic           rd_en;
    logic           ld;
    logic           dn;
    logic           bsy;
    logic           start_ok;
    logic           start_run;
    logic           last_word;
    logic           capture;

    // Unused encodings (6, 7) behave exactly like IDLE.
    always_comb begin
        state_dec = state;
        if (state > S_DONE) begin
            state_dec = S_IDLE;
        end
    end

    assign last_word = (index_q == (total_q - W'(1)));

    // Next state and strobes. Abort overrides every transition and
    // suppresses all strobes of the current cycle, including done.
    always_comb begin
        state_nxt = state_dec;
        rd_en     = 1'b0;
        ld        = 1'b0;
        dn        = 1'b0;
        bsy       = 1'b1;
        start_ok  = 1'b0;
        capture   = 1'b0;

        unique case (state_dec)
            S_IDLE: begin
                bsy = 1'b0;
                if (start_readback) begin
                    start_ok = 1'b1;
                    if (neuron_count == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RD_ISSUE;
                    end
                end
            end
            S_RD_ISSUE: begin
                rd_en     = 1'b1;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                capture   = 1'b1;
                state_nxt = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (tx_ready) begin
                    state_nxt = S_TX_LOAD;
                end
            end
            S_TX_LOAD: begin
                ld = 1'b1;
                if (last_word) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_RD_ISSUE;
                end
            end
            S_DONE: begin
                dn        = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                bsy       = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase

        if (abort) begin
            state_nxt = S_IDLE;
            rd_en     = 1'b0;
            ld        = 1'b0;
            dn        = 1'b0;
            start_ok  = 1'b0;
            capture   = 1'b0;
        end
    end

    assign start_run = start_ok && (neuron_count != '0);

    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transfer parameters are latched once so later input changes
    // cannot disturb a transfer in progress.
    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            base_q  <= '0;
            total_q <= '0;
            index_q <= '0;
        end else if (start_run) begin
            base_q  <= layer_postion ? BASE_ODD : BASE_EVEN;
            total_q <= neuron_count;
            index_q <= '0;
        end else if (ld && !last_word) begin
            index_q <= index_q + W'(1);
        end
    end

    // Single-word buffer between the memory and the shifter.
    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= mem_rd_data;
        end
    end

    // Cleared on any accepted start (including a zero-length one),
    // otherwise holds its count after done or abort.
    always_ff @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            sent_q <= '0;
        end else if (start_ok) begin
            sent_q <= '0;
        end else if (ld) begin
            sent_q <= sent_q + W'(1);
        end
    end

    // Address arithmetic wraps naturally at W bits.
    assign mem_rd_en  = rd_en;
    assign mem_addr   = rd_en ? (base_q + index_q) : '0;
    assign tx_load    = ld;
    assign tx_data    = ld ? hold_q : '0;
    assign busy       = bsy;
    assign done       = dn;
    assign words_sent = sent_q;

endmodule

// File: tb/tb_npu_result_reader.sv
// tb_npu_result_reader: randomized and directed scoreboard bench.
// Expected reads, words and done pulses are queued at start; a monitor checks them.
module tb_npu_result_reader;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        start_readback;
    logic        abort;
    logic        layer_postion;
    logic [15:0] neuron_count;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rd_data;
    logic        tx_ready;
    logic        tx_load;
    logic [15:0] tx_data;
    logic        busy;
    logic        done;
    logic [15:0] words_sent;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rdy_mode = 0;
    int rdy_ph   = 0;
    logic prev_rdy = 1'b0;

    logic [15:0] mem [0:65535];

    logic [15:0] exp_addr[$];
    logic [15:0] exp_data[$];
    int          exp_tx_cyc[$];
    int          exp_done_ws[$];
    int          exp_done_cyc[$];

    npu_result_reader dut (
        .clk            (clk),
        .reset_b        (reset_b),
        .start_readback (start_readback),
        .abort          (abort),
        .layer_postion  (layer_postion),
        .neuron_count   (neuron_count),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .tx_ready       (tx_ready),
        .tx_load        (tx_load),
        .tx_data        (tx_data),
        .busy           (busy),
        .done           (done),
        .words_sent     (words_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Port B memory: synchronous read, one cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // tx_ready generator: 0 always high, 1 random, 2 five low / one high, 3 low.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = 1'($urandom_range(0, 1));
            2: begin
                tx_ready = (rdy_ph == 5);
                rdy_ph   = (rdy_ph == 5) ? 0 : rdy_ph + 1;
            end
            default: tx_ready = 1'b0;
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    // Monitor: every strobe is compared with the head of its queue.
    always @(negedge clk) begin
        if (!reset_b) begin
            if (mem_rd_en) begin
                if (exp_addr.size() == 0) flag("unexpected_mem_rd_en");
                else check("rd_addr", mem_addr, exp_addr.pop_front());
            end
            if (tx_load) begin
                check("tx_after_ready", prev_rdy, 1'b1);
                if (exp_data.size() == 0) flag("unexpected_tx_load");
                else check("tx_data", tx_data, exp_data.pop_front());
                if (exp_tx_cyc.size() != 0)
                    check("tx_cycle", cyc, exp_tx_cyc.pop_front());
            end
            if (done) begin
                if (exp_done_ws.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    int c;
                    check("done_words_sent", words_sent, exp_done_ws.pop_front());
                    c = exp_done_cyc.pop_front();
                    if (c >= 0) check("done_cycle", cyc, c);
                end
            end
        end
        prev_rdy = tx_ready;
    end

    // Reference model: a transfer of n words reads base+i and sends mem[base+i].
    task automatic expect_xfer(input bit lay, input int n_rd, input int n_tx,
                               input bit with_done, input int ws,
                               input bit timed, input int sc);
        logic [15:0] base;
        logic [15:0] a;
        base = lay ? 16'd20440 : 16'd20400;
        for (int i = 0; i < n_rd; i++) begin
            a = base + 16'(i);
            exp_addr.push_back(a);
            if (i < n_tx) exp_data.push_back(mem[a]);
            if (timed && i < n_tx) exp_tx_cyc.push_back(sc + 4 * (i + 1));
        end
        if (with_done) begin
            exp_done_ws.push_back(ws);
            exp_done_cyc.push_back(timed ? sc + 4 * n_tx + 1 : -1);
        end
    endtask

    task automatic do_start(input bit lay, input logic [15:0] cnt, output int sc);
        @(posedge clk);
        #1;
        start_readback = 1'b1;
        layer_postion  = lay;
        neuron_count   = cnt;
        sc             = cyc;
        @(posedge clk);
        #1;
        start_readback = 1'b0;
        layer_postion  = 1'($urandom);
        neuron_count   = 16'($urandom);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        if (busy) flag({nm, "_timeout"});
        check({nm, "_addr_q_empty"}, exp_addr.size(), 0);
        check({nm, "_data_q_empty"}, exp_data.size(), 0);
        check({nm, "_done_q_empty"}, exp_done_ws.size(), 0);
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_busy"}, busy, 1'b0);
        check({nm, "_rd_en"}, mem_rd_en, 1'b0);
        check({nm, "_addr"}, mem_addr, 16'd0);
        check({nm, "_tx_load"}, tx_load, 1'b0);
        check({nm, "_tx_data"}, tx_data, 16'd0);
        check({nm, "_done"}, done, 1'b0);
        check({nm, "_words_sent"}, words_sent, 16'd0);
    endtask

    initial begin
        int sc;
        int k;
        int n;

        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[20400] = 16'h0011;
        mem[20401] = 16'h0022;
        mem[20402] = 16'h0033;

        reset_b        = 1'b1;
        start_readback = 1'b0;
        abort          = 1'b0;
        layer_postion  = 1'b0;
        neuron_count   = 16'd0;
        tx_ready       = 1'b0;

        repeat (3) @(posedge clk);
        #3;
        check_quiet("in_reset");
        reset_b = 1'b0;
        @(negedge clk);
        check_quiet("after_reset");

        // Basic stream with exact timing.
        rdy_mode = 0;
        do_start(1'b0, 16'd3, sc);
        expect_xfer(1'b0, 3, 3, 1'b1, 3, 1'b1, sc);
        wait_idle("basic", 200);
        check("basic_words_sent", words_sent, 16'd3);

        // Odd layer with backpressure; busy must stay high until done.
        rdy_mode = 2;
        do_start(1'b1, 16'd2, sc);
        expect_xfer(1'b1, 2, 2, 1'b1, 2, 1'b0, sc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("bp_busy", busy, 1'b1);
        end while (!done && n < 200);
        if (!done) flag("bp_done_timeout");
        wait_idle("bp", 50);

        // Zero count.
        rdy_mode = 0;
        do_start(1'b0, 16'd0, sc);
        expect_xfer(1'b0, 0, 0, 1'b1, 0, 1'b1, sc);
        wait_idle("zero", 50);
        check("zero_words_sent", words_sent, 16'd0);

        // Abort right after the 4th word is loaded.
        do_start(1'b0, 16'd10, sc);
        expect_xfer(1'b0, 4, 4, 1'b0, 0, 1'b0, sc);
        k = 0;
        n = 0;
        while (k < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (tx_load) k++;
        end
        if (k < 4) flag("abort_wait_timeout");
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_idle", busy, 1'b0);
        check("abort_words_sent", words_sent, 16'd4);
        wait_idle("abort", 20);

        do_start(1'b0, 16'd2, sc);
        expect_xfer(1'b0, 2, 2, 1'b1, 2, 1'b1, sc);
        wait_idle("after_abort", 100);

        // Restart attempt plus input change during a 5-word transfer.
        rdy_mode = 1;
        do_start(1'b0, 16'd5, sc);
        expect_xfer(1'b0, 5, 5, 1'b1, 5, 1'b0, sc);
        repeat (3) @(posedge clk);
        #1;
        start_readback = 1'b1;
        layer_postion  = 1'b1;
        neuron_count   = 16'd1;
        @(posedge clk);
        #1;
        start_readback = 1'b0;
        wait_idle("restart", 400);
        check("restart_words_sent", words_sent, 16'd5);

        // Asynchronous reset while waiting for the shifter.
        rdy_mode = 0;
        do_start(1'b1, 16'd3, sc);
        expect_xfer(1'b1, 2, 1, 1'b0, 0, 1'b0, sc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_load && n < 50);
        rdy_mode = 3;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_rd_en && n < 50);
        if (!mem_rd_en) flag("reset_wait_timeout");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_reset_words_sent", words_sent, 16'd1);
        #2;
        reset_b = 1'b1;
        #1;
        check_quiet("async_reset");
        #3;
        reset_b = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");
        check("reset_addr_q_empty", exp_addr.size(), 0);
        check("reset_data_q_empty", exp_data.size(), 0);

        rdy_mode = 0;
        do_start(1'b1, 16'd2, sc);
        expect_xfer(1'b1, 2, 2, 1'b1, 2, 1'b1, sc);
        wait_idle("post_reset_xfer", 100);

        // Randomized transfers with random backpressure.
        rdy_mode = 1;
        for (int t = 0; t < 25; t++) begin
            bit          lay;
            logic [15:0] cnt;
            lay = 1'($urandom);
            cnt = 16'($urandom_range(0, 6));
            do_start(lay, cnt, sc);
            expect_xfer(lay, int'(cnt), int'(cnt), 1'b1, int'(cnt), 1'b0, sc);
            wait_idle("rand", 600);
            check("rand_words_sent", words_sent, cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npu_result_reader.md
Name: npu_result_reader

Overview:
- Read-side counterpart of the NPU memory controller's SPI write path.
- After a layer finishes, streams the activation results from memory port B to the SPI transmit shifter, one word per handshake.
- Starts at the result base address selected by layer position and reads neuron_count consecutive words.
- Sits between the NPU top-level FSM (start/abort), the shared dual-port memory (port B read), and the SPI slave TX shifter.

Parameters:
- NPU_DATA_WIDTH, 16, width of data words, addresses and counts.
- BASE_ADDR_EVEN, 20400, result region base when layer_postion = 0.
- BASE_ADDR_ODD, 20440, result region base when layer_postion = 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_b  input  1  asynchronous, active-high reset (asserted = 1); the name follows codebase convention, polarity is high.
- start_readback  input  1  single-cycle request to begin streaming; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns the block to IDLE from any state.
- layer_postion  input  1  selects the base address; latched at start.
- neuron_count  input  NPU_DATA_WIDTH  number of words to send; latched at start.
- mem_rd_en  output  1  memory port B read strobe.
- mem_addr  output  NPU_DATA_WIDTH  memory port B address.
- mem_rd_data  input  NPU_DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- tx_ready  input  1  SPI shifter can accept a word this cycle.
- tx_load  output  1  single-cycle strobe; tx_data is valid when this is 1.
- tx_data  output  NPU_DATA_WIDTH  word to transmit.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse after the last word is loaded.
- words_sent  output  NPU_DATA_WIDTH  count of tx_load strobes in the current transfer.

Behaviour:
- Reset values: all outputs 0, state IDLE, base/total/index/hold registers 0.
- States:
  - IDLE: busy = 0.
    - On start_readback = 1 and neuron_count != 0: latch base (layer_postion ? BASE_ADDR_ODD : BASE_ADDR_EVEN), latch total = neuron_count, clear index and words_sent, go to RD_ISSUE.
    - On start_readback = 1 and neuron_count == 0: go to DONE with no memory or TX activity.
  - RD_ISSUE: mem_rd_en = 1, mem_addr = base + index (modulo 2^NPU_DATA_WIDTH); next state RD_WAIT.
  - RD_WAIT: capture mem_rd_data into the hold register; next state TX_WAIT.
  - TX_WAIT: stay while tx_ready = 0; when tx_ready = 1, go to TX_LOAD.
  - TX_LOAD: tx_load = 1, tx_data = hold; words_sent increments. If index == total - 1, go to DONE; otherwise index increments and go to RD_ISSUE.
  - DONE: done = 1 for one cycle; next state IDLE. words_sent holds its value until the next start.
- mem_addr and tx_data are 0 whenever their strobe is low.
- Per-word latency:
  - Minimum 4 cycles (RD_ISSUE, RD_WAIT, TX_WAIT, TX_LOAD) when tx_ready is held high.
  - From start to first tx_load: 4 cycles.
  - From last tx_load to done: 1 cycle.
- Handshake rules:
  - tx_load is asserted only in the cycle after tx_ready was seen high in TX_WAIT.
  - tx_ready is ignored in all other states.
  - The block never issues the next read before the current word is loaded (single-word buffering).
- Boundary conditions:
  - start_readback while busy: ignored, latched values unchanged.
  - abort has priority over every transition, including start in IDLE and the DONE pulse. Abort → IDLE next cycle, no done, no further strobes; words_sent keeps its partial count.
  - Address wrap: base + index wraps modulo 2^NPU_DATA_WIDTH; no error is flagged.
  - neuron_count or layer_postion changing mid-transfer has no effect, because both are latched.
  - reset_b asserted mid-transfer: immediate asynchronous return to reset values; any tx_load in flight is dropped.
- Illegal state encodings decode to IDLE.

Test Plan:
- Basic stream: layer_postion = 0, neuron_count = 3, memory[20400..20402] = 0x0011, 0x0022, 0x0033, tx_ready = 1 → mem_addr 20400, 20401, 20402; tx_data 0x0011, 0x0022, 0x0033 on tx_load at cycles 4, 8, 12 after start; done at cycle 13; words_sent = 3.
- Odd layer with backpressure: layer_postion = 1, neuron_count = 2, tx_ready low for 5 cycles each word → reads at 20440 and 20441; each tx_load occurs 1 cycle after tx_ready rises; exactly 2 tx_load pulses; busy stays high throughout.
- Zero count: neuron_count = 0 with start → no mem_rd_en and no tx_load; done pulses 1 cycle after start; words_sent = 0.
- Abort mid-stream: neuron_count = 10, abort asserted after the 4th tx_load → IDLE next cycle; no done; words_sent = 4; a new start afterwards restarts reading at the base address.
- Ignored restart and input change: second start plus neuron_count changed to 1 during a 5-word transfer → 5 words still sent from the original base.
- Async reset mid-transfer: reset_b pulsed high during TX_WAIT → all outputs 0 in the same cycle; IDLE after release; the next start works normally.
